// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake from the host link plus the
// word-aligned instruction-memory write port driven by the loader.
// master = host/memory side, slave = loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
// Receives LEN_LO, LEN_HI (word count N), then 4*N little-endian payload
// bytes, writes each assembled word to instruction memory and holds the
// core in reset until a complete, in-range image has been written.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte covering the length and payload bytes.
module imem_loader #(
  parameter int unsigned DEPTH = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] LP_DEPTH = 16'(DEPTH);

  state_t      r_state;
  logic [15:0] r_len;
  logic [15:0] r_idx;
  logic [1:0]  r_lane;
  logic [23:0] r_asm;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  logic        w_ready;
  logic        w_accept;
  logic [15:0] w_len;
  logic        w_last_word;

  // in_ready is a pure decode of the state register
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_LEN0, S_LEN1, S_DATA: w_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                 w_ready = 1'b1;
`endif
      default:                w_ready = 1'b0;
    endcase
  end

  assign bus.in_ready = w_ready;
  assign w_accept     = bus.in_valid && w_ready;
  assign w_len        = {bus.in_data, r_len[7:0]};
  assign w_last_word  = (r_idx == (r_len - 16'd1));

  // Session FSM with registered status and write-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_idx        <= '0;
      r_lane       <= '0;
      r_asm        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor        <= '0;
`endif
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wd   <= '0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state   <= S_LEN0;
            r_idx     <= '0;
            r_lane    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor     <= '0;
`endif
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
          end
        end

        S_LEN0: begin
          if (w_accept) begin
            r_len[7:0] <= bus.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ bus.in_data;
`endif
            r_state    <= S_LEN1;
          end
        end

        S_LEN1: begin
          if (w_accept) begin
            r_len[15:8] <= bus.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor       <= r_xor ^ bus.in_data;
`endif
            if (w_len > LP_DEPTH) begin
              r_state <= S_ERR;
              err     <= 1'b1;
              busy    <= 1'b0;
            end else if (w_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state   <= S_CSUM;
`else
              r_state   <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              busy      <= 1'b0;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor  <= r_xor ^ bus.in_data;
`endif
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_asm[7:0]   <= bus.in_data;
              2'd1: r_asm[15:8]  <= bus.in_data;
              2'd2: r_asm[23:16] <= bus.in_data;
              default: begin
                // lane-3 byte goes straight into the write word
                bus.mem_we   <= 1'b1;
                bus.mem_wd   <= {bus.in_data, r_asm};
                bus.mem_addr <= {14'd0, r_idx, 2'b00};
                r_idx        <= r_idx + 16'd1;
                if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_state   <= S_CSUM;
`else
                  r_state   <= S_DONE;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
                  busy      <= 1'b0;
`endif
                end
              end
            endcase
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            busy <= 1'b0;
            if (bus.in_data == r_xor) begin
              r_state   <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              r_state <= S_ERR;
              err     <= 1'b1;
            end
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven sessions plus hand-written corner cases;
// memory writes are checked against a scoreboard queue.
module tb_imem_loader;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_reset, busy, done, err;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t q[$];
  wr_t mon_e;

  typedef struct {
    logic [15:0]       n;
    logic [3:0][31:0]  w;
    bit                gap;
    bit                bad_cs;
    bit                exp_done;
    bit                exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // every write strobe must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got addr %h data %h want no write", bus.mem_addr, bus.mem_wd);
      end else begin
        mon_e = q.pop_front();
        check("we_addr", bus.mem_addr, mon_e.addr);
        check("we_data", bus.mem_wd, mon_e.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [15:0] n, input logic [31:0] a, b, c, d,
                              input bit gap, input bit bcs, input bit ed, input bit ee);
    vec_t v;
    v.n = n;
    v.w = {d, c, b, a};
    v.gap = gap;
    v.bad_cs = bcs;
    v.exp_done = ed;
    v.exp_err = ee;
    return v;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // presents one byte, waits (bounded) for in_ready, returns at the
  // falling edge after the accepting rising edge
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int k;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got in_ready %b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] word;
    do_start();
    check({tag, "_start_busy"}, 32'(busy), 32'd1);
    check({tag, "_start_done"}, 32'(done), 32'd0);
    check({tag, "_start_err"},  32'(err),  32'd0);
    check({tag, "_start_cpurst"}, 32'(cpu_reset), 32'd1);
    x = 8'h00;
    send_byte(v.n[7:0], v.gap);
    x ^= v.n[7:0];
    send_byte(v.n[15:8], v.gap);
    x ^= v.n[15:8];
    if (v.n <= 16'(DEPTH)) begin
      for (int w = 0; w < int'(v.n); w++) begin
        word = v.w[w % 4];
        for (int l = 0; l < 4; l++) begin
          b = word[8*l +: 8];
          x ^= b;
          if (l == 3) q.push_back('{32'(w * 4), word});
          send_byte(b, v.gap);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(v.bad_cs ? (x ^ 8'h01) : x, v.gap);
`else
      if (v.n != 16'd0) check({tag, "_final_we"}, 32'(bus.mem_we), 32'd1);
`endif
    end
    check({tag, "_done"},   32'(done),      32'(v.exp_done));
    check({tag, "_err"},    32'(err),       32'(v.exp_err));
    check({tag, "_cpurst"}, 32'(cpu_reset), 32'(!v.exp_done));
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_ready"},  32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check({tag, "_pending"}, 32'(q.size()), 32'd0);
    check({tag, "_sticky_done"}, 32'(done), 32'(v.exp_done));
  endtask

  initial begin
    vecs.push_back(mk(16'd2,  32'he04f000f, 32'he04f100f, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(16'd2,  32'he04f000f, 32'he04f100f, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(16'd65, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(16'd0,  32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(16'd4,  32'h12345678, 32'hdeadbeef, 32'h00000000, 32'hffffffff, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(16'd1,  32'ha5a55a5a, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(16'd64, 32'h01020304, 32'h80706050, 32'hc0ffee11, 32'h7e7e0001, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(16'h0100, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1));
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs.push_back(mk(16'd1,  32'h00000013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(16'd2,  32'he04f000f, 32'he04f100f, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
`endif

    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(bus.in_ready), 32'd0);
    check("rst_we",     32'(bus.mem_we),   32'd0);
    check("rst_addr",   bus.mem_addr,      32'd0);
    check("rst_wd",     bus.mem_wd,        32'd0);
    check("rst_cpurst", 32'(cpu_reset),    32'd1);
    check("rst_busy",   32'(busy),         32'd0);
    check("rst_done",   32'(done),         32'd0);
    check("rst_err",    32'(err),          32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset arriving with the lane-3 byte: strobe dropped, back to idle
    do_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h0f, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h4f, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'he0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check("mrst_ready",  32'(bus.in_ready), 32'd0);
    check("mrst_we",     32'(bus.mem_we),   32'd0);
    check("mrst_cpurst", 32'(cpu_reset),    32'd1);
    check("mrst_busy",   32'(busy),         32'd0);
    check("mrst_done",   32'(done),         32'd0);
    check("mrst_err",    32'(err),          32'd0);
    @(negedge clk);
    check("mrst_idle_ready", 32'(bus.in_ready), 32'd0);

    // start pulses during a session are ignored, alone or with a byte
    do_start();
    send_byte(8'h00, 1'b0);
    do_start();
    check("ign_busy",  32'(busy),          32'd1);
    check("ign_ready", 32'(bus.in_ready),  32'd1);
    start = 1'b1;
    send_byte(8'h00, 1'b0);
    start = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    check("ign_done",   32'(done),      32'd1);
    check("ign_err",    32'(err),       32'd0);
    check("ign_busy_end", 32'(busy),    32'd0);
    check("ign_cpurst", 32'(cpu_reset), 32'd0);
    repeat (3) @(negedge clk);
    check("ign_sticky", 32'(done), 32'd1);
    check("ign_pending", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
